// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between a byte producer, the transmit FIFO and the UART byte transmitter.
// The master side is the producer/transmitter pair; the FIFO itself uses the slave side.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [7:0]        tx_data;
    logic              tx_send_en;
    logic              tx_done;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              tx_timeout;

    modport master (
        output wr_en, wr_data, tx_done,
        input  tx_data, tx_send_en, full, empty, level, overflow, drop_cnt, tx_timeout
    );

    modport slave (
        input  wr_en, wr_data, tx_done,
        output tx_data, tx_send_en, full, empty, level, overflow, drop_cnt, tx_timeout
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer: buffers bursts of incoming bytes and feeds the UART
// transmitter one byte per frame, waiting for tx_done (or an optional watchdog) between bytes.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Watchdog fires on the WAIT edge where the counter would reach TIMEOUT_CYC-1,
    // which lands the tx_timeout pulse TIMEOUT_CYC cycles after the send pulse.
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 2) ? WD_W'(TIMEOUT_CYC - 2) : '0;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [WD_W-1:0]    wd_cnt;
    logic [7:0]         tx_data_q;
    logic               send_q;
    logic               timeout_q;
    logic               overflow_q;
    logic [7:0]         drop_q;
    logic               push;
    logic               pop;

    assign bus.full       = (count == CNT_W'(DEPTH));
    assign bus.empty      = (count == '0);
    assign bus.level      = count;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_send_en = send_q;
    assign bus.tx_timeout = timeout_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_q;

    assign push = bus.wr_en && !bus.full;
    assign pop  = (state == IDLE) && !bus.empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= bus.wr_en && bus.full;
            if (bus.wr_en && bus.full && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_data_q <= '0;
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr];
                        send_q    <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end else if (TIMEOUT_CYC != 0 && wd_cnt >= WD_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle vectors, directed corner sequences and a
// randomized run scored against a queue model of accepted bytes.
module tb_uart_tx_fifo;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int WD_TIMEOUT = 20;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wdata;
        logic       done;
        logic       send;
        logic [7:0] data;
        logic [4:0] level;
        logic       empty;
        logic       full;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic auto_done;
    logic man_done;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();
    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) wd_bus ();

    assign bus.tx_done = auto_done | man_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(WD_TIMEOUT)) dut_wd (
        .clk(clk), .reset(reset), .bus(wd_bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int sent_data[$];
    int sent_cyc[$];
    int done_cyc[$];
    int exp_q[$];
    int n_acc        = 0;
    int n_rej        = 0;
    int ovf_pulses   = 0;
    int max_level    = 0;
    bit prev_send    = 1'b0;
    bit sb_on        = 1'b0;
    bit auto_on      = 1'b0;
    bit rand_frames  = 1'b0;
    int frame_len    = 1;
    vec_t vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        reset       = v.rst;
        bus.wr_en   = v.wr;
        bus.wr_data = v.wdata;
        man_done    = v.done;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_send", idx), bus.tx_send_en, v.send);
        checkOutput($sformatf("vec%0d_data", idx), bus.tx_data, v.data);
        checkOutput($sformatf("vec%0d_level", idx), bus.level, v.level);
        checkOutput($sformatf("vec%0d_empty", idx), bus.empty, v.empty);
        checkOutput($sformatf("vec%0d_full", idx), bus.full, v.full);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Acceptance follows the registered count: accepted writes minus bytes already issued.
    task automatic pushByte(input int d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d[7:0];
        if (n_acc - sent_data.size() < DEPTH) begin
            exp_q.push_back(d & 8'hFF);
            n_acc++;
        end else begin
            n_rej++;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulseDone();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic waitSends(input int n, input int budget);
        int left = budget;
        while (sent_data.size() < n && left > 0) begin
            @(negedge clk);
            left--;
        end
        checkOutput("send_count", sent_data.size(), n);
    endtask

    task automatic resetDut();
        auto_on     = 1'b0;
        sb_on       = 1'b0;
        bus.wr_en   = 1'b0;
        man_done    = 1'b0;
        idleCycles(60);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sent_data.delete();
        sent_cyc.delete();
        done_cyc.delete();
        exp_q.delete();
        n_acc      = 0;
        n_rej      = 0;
        ovf_pulses = 0;
        max_level  = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.tx_send_en) begin
                checkOutput("send_gap", prev_send, 0);
                sent_data.push_back(bus.tx_data);
                sent_cyc.push_back(cyc);
                if (sb_on) begin
                    checkOutput("send_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        checkOutput("send_order", bus.tx_data, exp_q.pop_front());
                    end
                end
            end
            prev_send = bus.tx_send_en;
            if (bus.tx_done) done_cyc.push_back(cyc);
            if (bus.overflow) ovf_pulses++;
            if (int'(bus.level) > max_level) max_level = bus.level;
            if (sb_on) begin
                checkOutput("level_model", bus.level, n_acc - sent_data.size());
                checkOutput("full_model", bus.full, (n_acc - sent_data.size()) == DEPTH);
            end
        end
    end

    // Transmitter model: raises tx_done for one cycle, frame_len cycles after each send pulse.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_on && bus.tx_send_en) begin
                repeat (rand_frames ? $urandom_range(1, 12) : frame_len) @(posedge clk);
                @(negedge clk);
                if (auto_on) auto_done = 1'b1;
                @(negedge clk);
                auto_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] stopped by global timeout");
    end

    initial begin
        int w;
        int t_send;
        int t_to;
        int t2;
        int n0;

        reset          = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        man_done       = 1'b0;
        wd_bus.wr_en   = 1'b0;
        wd_bus.wr_data = '0;
        wd_bus.tx_done = 1'b0;

        //                 rst   wr    wdata  done  send  data   level empty full
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h22, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("vec_overflow", bus.overflow, 0);
        checkOutput("vec_drop_cnt", bus.drop_cnt, 0);

        $display("[TB] single byte latency");
        resetDut();
        sb_on = 1'b1;
        idleCycles(10);
        w = cyc;
        pushByte(8'hA5);
        waitSends(1, 10);
        if (sent_cyc.size() > 0) checkOutput("single_latency", sent_cyc[0], w + 2);
        idleCycles(100);
        pulseDone();
        idleCycles(20);
        checkOutput("single_empty", bus.empty, 1);
        checkOutput("single_no_resend", sent_data.size(), 1);

        $display("[TB] burst of five");
        resetDut();
        sb_on       = 1'b1;
        auto_on     = 1'b1;
        rand_frames = 1'b0;
        frame_len   = 50;
        for (int i = 1; i <= 5; i++) pushByte(i);
        waitSends(5, 400);
        for (int i = 1; i < sent_cyc.size() && i < done_cyc.size() + 1; i++) begin
            checkOutput($sformatf("burst_gap%0d", i), sent_cyc[i], done_cyc[i-1] + 1);
        end
        idleCycles(60);
        checkOutput("burst_total", sent_data.size(), 5);
        checkOutput("burst_empty", bus.empty, 1);

        // 18 back-to-back writes: byte 0 pops alongside write 1, so 16 stay stored and only
        // write 18 is rejected; a 19th write gives the second rejection.
        $display("[TB] overflow");
        resetDut();
        sb_on = 1'b1;
        for (int i = 0; i < 18; i++) pushByte(8'h80 + i);
        checkOutput("ovf_level", bus.level, 16);
        checkOutput("ovf_full", bus.full, 1);
        checkOutput("ovf_drop1", bus.drop_cnt, 1);
        checkOutput("ovf_pulses1", ovf_pulses, 1);
        pushByte(8'hEF);
        checkOutput("ovf_drop2", bus.drop_cnt, 2);
        checkOutput("ovf_pulses2", ovf_pulses, 2);
        checkOutput("ovf_model_rej", bus.drop_cnt, n_rej);
        pulseDone();
        pushByte(8'hEE);
        checkOutput("ovf_pop_while_full_drop", bus.drop_cnt, 3);
        checkOutput("ovf_after_pop_level", bus.level, 15);
        checkOutput("ovf_second_byte", sent_data.size() > 1 ? sent_data[1] : -1, 8'h81);

        $display("[TB] streaming wrap");
        resetDut();
        sb_on       = 1'b1;
        auto_on     = 1'b1;
        rand_frames = 1'b0;
        frame_len   = 1;
        pushByte(0);
        pushByte(1);
        for (int k = 2; k < 40; k++) begin
            idleCycles(2);
            pushByte(k);
        end
        waitSends(40, 200);
        checkOutput("stream_max_level", max_level, 1);
        checkOutput("stream_model_drained", exp_q.size(), 0);
        checkOutput("stream_last", sent_data.size() == 40 ? sent_data[39] : -1, 8'h27);

        $display("[TB] randomized traffic");
        resetDut();
        sb_on       = 1'b1;
        auto_on     = 1'b1;
        rand_frames = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1) pushByte($urandom_range(0, 255));
            else idleCycles(1);
        end
        waitSends(n_acc, 600);
        checkOutput("rand_model_drained", exp_q.size(), 0);
        checkOutput("rand_drop_cnt", bus.drop_cnt, n_rej > 255 ? 255 : n_rej);
        checkOutput("rand_ovf_pulses", ovf_pulses, n_rej);
        checkOutput("rand_empty", bus.empty, 1);

        $display("[TB] watchdog");
        resetDut();
        wd_bus.wr_en   = 1'b1;
        wd_bus.wr_data = 8'h3C;
        @(negedge clk);
        wd_bus.wr_data = 8'h3D;
        @(negedge clk);
        wd_bus.wr_en = 1'b0;
        t_send = -1;
        for (int i = 0; i < 10 && t_send < 0; i++) begin
            if (wd_bus.tx_send_en) begin
                t_send = cyc;
                checkOutput("wd_first_data", wd_bus.tx_data, 8'h3C);
            end else begin
                @(negedge clk);
            end
        end
        t_to = -1;
        for (int i = 0; i < 40 && t_to < 0; i++) begin
            @(negedge clk);
            if (wd_bus.tx_timeout) t_to = cyc;
        end
        checkOutput("wd_timeout_delay", t_to - t_send, WD_TIMEOUT);
        t2 = -1;
        for (int i = 0; i < 5 && t2 < 0; i++) begin
            @(negedge clk);
            checkOutput("wd_timeout_one_cycle", wd_bus.tx_timeout, 0);
            if (wd_bus.tx_send_en) begin
                t2 = cyc;
                checkOutput("wd_second_data", wd_bus.tx_data, 8'h3D);
            end
        end
        checkOutput("wd_second_gap", t2 - t_to, 1);

        $display("[TB] reset mid-burst");
        resetDut();
        for (int i = 0; i < 6; i++) pushByte(8'h60 + i);
        idleCycles(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_send", bus.tx_send_en, 0);
        checkOutput("rst_data", bus.tx_data, 0);
        checkOutput("rst_level", bus.level, 0);
        checkOutput("rst_empty", bus.empty, 1);
        checkOutput("rst_full", bus.full, 0);
        checkOutput("rst_overflow", bus.overflow, 0);
        checkOutput("rst_drop", bus.drop_cnt, 0);
        checkOutput("rst_timeout", bus.tx_timeout, 0);
        n0 = sent_data.size();
        pulseDone();
        idleCycles(5);
        checkOutput("rst_late_done_ignored", sent_data.size(), n0);
        w = cyc;
        pushByte(8'h77);
        idleCycles(3);
        checkOutput("rst_new_count", sent_data.size(), n0 + 1);
        if (sent_data.size() > n0) begin
            checkOutput("rst_new_data", sent_data[n0], 8'h77);
            checkOutput("rst_new_latency", sent_cyc[n0], w + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
